// File: rtl/mul_wb_arbiter_pkg.sv
// Shared types and default sizing for the writeback arbiter and its result FIFO.
package mul_wb_arbiter_pkg;

  localparam int MUL_BUF_DEPTH_DEFAULT = 4;
  localparam int STARVE_LIMIT_DEFAULT  = 3;
  localparam int REG_ADDR_W            = 5;

  // Decoded instruction as it travels toward the register-file write port.
  typedef struct packed {
    logic                  valid;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } inst_decoded_t;

endpackage

// File: rtl/mul_wb_arbiter_fifo.sv
// mul_result_fifo: circular buffer of multiplier results that lost arbitration.
// Exposes per-slot occupancy and rd so the arbiter can detect write-after-write
// ordering hazards against the ALU stream.
module mul_result_fifo
  import mul_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = MUL_BUF_DEPTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push_i,
  input  logic                                pop_i,
  input  logic                                flush_i,
  input  inst_decoded_t                       din_i,
  output inst_decoded_t                       head_o,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [DEPTH-1:0]                    ent_valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  inst_decoded_t   mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately not reset; occupancy is tracked
    // by the pointers and count alone, so stale slots are never observed.
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off            = PW'(i) - rd_ptr_q;
    assign ent_valid_o[i] = ({1'b0, off} < count_q);
    assign ent_rd_o[i]    = mem_q[i].rd;
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// mul_wb_arbiter: merges the in-order ALU/MEM writeback stream and the
// multiplier result stream onto the single register-file write port.
// Optional build macro WB_PERF_CNT_EN adds saturating event counters.
module mul_wb_arbiter
  import mul_wb_arbiter_pkg::*;
#(
  parameter int MUL_BUF_DEPTH = MUL_BUF_DEPTH_DEFAULT,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  inst_decoded_t inst_alu_in,
  input  inst_decoded_t inst_mul_in,
  input  logic          kill_wb,
  output inst_decoded_t inst_wb_out,
  output logic          stall_mul_out,
  output logic          stall_alu_out
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   mul_stall_cnt,
  output logic [31:0]   alu_stall_cnt
`endif
);

  localparam int CW = $clog2(MUL_BUF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  inst_decoded_t                          fifo_head;
  logic [CW-1:0]                          fifo_count;
  logic                                   fifo_full;
  logic                                   fifo_empty;
  logic                                   fifo_push;
  logic                                   fifo_pop;
  logic [MUL_BUF_DEPTH-1:0]               ent_valid;
  logic [MUL_BUF_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

  inst_decoded_t wb_q, wb_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mul_v, fifo_hit, hazard, bypass, alu_win;

  mul_result_fifo #(.DEPTH(MUL_BUF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (kill_wb),
    .din_i       (inst_mul_in),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  // Per-cycle winner selection, FIFO control and back-pressure.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    wb_d          = '0;
    fifo_pop      = 1'b0;
    bypass        = 1'b0;
    alu_win       = 1'b0;
    stall_alu_out = 1'b0;
    fifo_hit      = 1'b0;

    // A killed multiplier result is never buffered, bypassed or matched.
    mul_v = inst_mul_in.valid && !kill_wb;

    for (int i = 0; i < MUL_BUF_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == inst_alu_in.rd)) fifo_hit = 1'b1;
    end

    // An older multiplier write to the same rd must land before the ALU write.
    hazard = !kill_wb && inst_alu_in.valid && inst_alu_in.rf_we &&
             (fifo_hit || (mul_v && (inst_mul_in.rd == inst_alu_in.rd)));

    if (kill_wb) begin
      // The ALU instruction is older than the kill point and still retires.
      if (inst_alu_in.valid) begin
        wb_d    = inst_alu_in;
        alu_win = 1'b1;
      end
    end else if (hazard) begin
      stall_alu_out = 1'b1;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        wb_d     = fifo_head;
      end else begin
        bypass = 1'b1;
        wb_d   = inst_mul_in;
      end
    end else if (starve_q == SW'(STARVE_LIMIT)) begin
      stall_alu_out = 1'b1;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        wb_d     = fifo_head;
      end
    end else if (inst_alu_in.valid) begin
      wb_d    = inst_alu_in;
      alu_win = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      wb_d     = fifo_head;
    end else if (mul_v) begin
      bypass = 1'b1;
      wb_d   = inst_mul_in;
    end

    // A full buffer only accepts a new result when a slot frees this cycle.
    stall_mul_out = fifo_full && !fifo_pop && !kill_wb;
    fifo_push     = mul_v && !bypass && !stall_mul_out;

    starve_d = starve_q;
    if (kill_wb || fifo_pop) begin
      starve_d = '0;
    end else if ((fifo_count == CW'(MUL_BUF_DEPTH)) && alu_win &&
                 (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Registered write-port winner and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      starve_q <= '0;
    end else begin
      wb_q     <= wb_d;
      starve_q <= starve_d;
    end
  end

  assign inst_wb_out = wb_q;

`ifdef WB_PERF_CNT_EN
  // Saturating event counters for arbitration conflicts and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt  <= '0;
      mul_stall_cnt <= '0;
      alu_stall_cnt <= '0;
    end else begin
      if (inst_alu_in.valid && inst_mul_in.valid && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 32'd1;
      if (stall_mul_out && (mul_stall_cnt != '1))
        mul_stall_cnt <= mul_stall_cnt + 32'd1;
      if (stall_alu_out && (alu_stall_cnt != '1))
        alu_stall_cnt <= alu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Scoreboard bench for mul_wb_arbiter: expected write-port results are queued
// as stimulus is driven and popped by a monitor as the DUT emits them.
module tb_mul_wb_arbiter;
  import mul_wb_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          kill_wb;
  inst_decoded_t inst_alu_in;
  inst_decoded_t inst_mul_in;
  inst_decoded_t inst_wb_out;
  logic          stall_mul_out;
  logic          stall_alu_out;
`ifdef WB_PERF_CNT_EN
  logic [31:0]   conflict_cnt;
  logic [31:0]   mul_stall_cnt;
  logic [31:0]   alu_stall_cnt;
`endif

  int            tests_run    = 0;
  int            tests_failed = 0;
  inst_decoded_t exp_q[$];
  inst_decoded_t exp_item;

  always #5 clk = ~clk;

  mul_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .inst_alu_in   (inst_alu_in),
    .inst_mul_in   (inst_mul_in),
    .kill_wb       (kill_wb),
    .inst_wb_out   (inst_wb_out),
    .stall_mul_out (stall_mul_out),
    .stall_alu_out (stall_alu_out)
`ifdef WB_PERF_CNT_EN
    ,
    .conflict_cnt  (conflict_cnt),
    .mul_stall_cnt (mul_stall_cnt),
    .alu_stall_cnt (alu_stall_cnt)
`endif
  );

  function automatic inst_decoded_t mk(input logic [4:0] rd, input logic [31:0] data);
    mk       = '0;
    mk.valid = 1'b1;
    mk.rf_we = 1'b1;
    mk.rd    = rd;
    mk.data  = data;
  endfunction

  // Scoreboard monitor: every valid write-port result must match the queue head.
  always @(posedge clk) begin
    #1;
    if (!rst && inst_wb_out.valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no output",
                 inst_wb_out.rd, inst_wb_out.data);
      end else begin
        exp_item = exp_q.pop_front();
        if (inst_wb_out !== exp_item) begin
          tests_failed++;
          $display("FAIL wb_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   inst_wb_out.rd, inst_wb_out.data, exp_item.rd, exp_item.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 ns");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_alu_in = '0;
    inst_mul_in = '0;
    kill_wb     = 1'b0;
  endtask

  task automatic check_drained(input string name);
    cycle();
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d results never emitted, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) cycle();
    tests_run += 4;
    if (inst_wb_out.valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", inst_wb_out.valid);
    end
    if (stall_mul_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall_mul: got %b expected 0", stall_mul_out);
    end
    if (stall_alu_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall_alu: got %b expected 0", stall_alu_out);
    end
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d expected 0", dut.u_fifo.count_o);
    end
`ifdef WB_PERF_CNT_EN
    tests_run++;
    if ((conflict_cnt | mul_stall_cnt | alu_stall_cnt) !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0",
               conflict_cnt, mul_stall_cnt, alu_stall_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_mul_only();
    idle_inputs();
    inst_mul_in = mk(5'd5, 32'h0000_0505);
    exp_q.push_back(inst_mul_in);
    cycle();
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL mul_only_count: got %0d expected 0", dut.u_fifo.count_o);
    end
    idle_inputs();
    check_drained("mul_only");
  endtask

  task automatic test_conflict();
    idle_inputs();
    inst_alu_in = mk(5'd3, 32'h0000_0303);
    inst_mul_in = mk(5'd7, 32'h0000_0707);
    exp_q.push_back(inst_alu_in);
    exp_q.push_back(inst_mul_in);
    cycle();
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd1) begin
      tests_failed++; $display("FAIL conflict_count1: got %0d expected 1", dut.u_fifo.count_o);
    end
    idle_inputs();
    cycle();
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL conflict_count0: got %0d expected 0", dut.u_fifo.count_o);
    end
    check_drained("conflict");
  endtask

  task automatic test_full();
    int   a = 0;
    int   m = 0;
    logic exp_smul, exp_salu;
    idle_inputs();
    for (int c = 0; c < 9; c++) begin
      inst_alu_in = mk(5'(1 + a), 32'(256 + a));
      inst_mul_in = mk(5'(16 + m), 32'(512 + m));
      exp_smul = (c >= 4) && (c != 7);
      exp_salu = (c == 7);
      if (exp_salu) exp_q.push_back(mk(5'd16, 32'd512));
      else          exp_q.push_back(inst_alu_in);
      #1;
      tests_run += 2;
      if (stall_mul_out !== exp_smul) begin
        tests_failed++; $display("FAIL full_stall_mul c%0d: got %b expected %b", c, stall_mul_out, exp_smul);
      end
      if (stall_alu_out !== exp_salu) begin
        tests_failed++; $display("FAIL full_stall_alu c%0d: got %b expected %b", c, stall_alu_out, exp_salu);
      end
      cycle();
      if (!exp_salu) a++;
      if (!exp_smul) m++;
    end
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd4) begin
      tests_failed++; $display("FAIL full_count: got %0d expected 4", dut.u_fifo.count_o);
    end
    idle_inputs();
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(5'(16 + k), 32'(512 + k)));
    repeat (4) cycle();
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL full_drain_count: got %0d expected 0", dut.u_fifo.count_o);
    end
    check_drained("full");
  endtask

  task automatic test_hazard();
    inst_decoded_t alu_seq [5];
    inst_decoded_t mul_seq [5];
    logic          exp_salu [5];
    alu_seq[0] = mk(5'd1, 32'h0000_0001);  mul_seq[0] = mk(5'd9, 32'h0000_0900);  exp_salu[0] = 1'b0;
    alu_seq[1] = mk(5'd9, 32'h0000_009A);  mul_seq[1] = '0;                       exp_salu[1] = 1'b1;
    alu_seq[2] = mk(5'd9, 32'h0000_009A);  mul_seq[2] = '0;                       exp_salu[2] = 1'b0;
    alu_seq[3] = mk(5'd12, 32'h0000_00CA); mul_seq[3] = mk(5'd12, 32'h0000_0C00); exp_salu[3] = 1'b1;
    alu_seq[4] = mk(5'd12, 32'h0000_00CA); mul_seq[4] = '0;                       exp_salu[4] = 1'b0;
    exp_q.push_back(alu_seq[0]);
    exp_q.push_back(mul_seq[0]);
    exp_q.push_back(alu_seq[2]);
    exp_q.push_back(mul_seq[3]);
    exp_q.push_back(alu_seq[4]);
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      inst_alu_in = alu_seq[c];
      inst_mul_in = mul_seq[c];
      #1;
      tests_run++;
      if (stall_alu_out !== exp_salu[c]) begin
        tests_failed++; $display("FAIL hazard_stall_alu c%0d: got %b expected %b", c, stall_alu_out, exp_salu[c]);
      end
      cycle();
    end
    idle_inputs();
    check_drained("hazard");
  endtask

  task automatic test_kill();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      inst_alu_in = mk(5'(20 + c), 32'(4096 + c));
      inst_mul_in = mk(5'(25 + c), 32'(8192 + c));
      exp_q.push_back(inst_alu_in);
      cycle();
    end
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd3) begin
      tests_failed++; $display("FAIL kill_pre_count: got %0d expected 3", dut.u_fifo.count_o);
    end
    kill_wb     = 1'b1;
    inst_alu_in = mk(5'd2, 32'h0000_0222);
    inst_mul_in = mk(5'd28, 32'h0000_0280);
    exp_q.push_back(inst_alu_in);
    #1;
    tests_run++;
    if (stall_alu_out !== 1'b0) begin
      tests_failed++; $display("FAIL kill_stall_alu: got %b expected 0", stall_alu_out);
    end
    cycle();
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL kill_count: got %0d expected 0", dut.u_fifo.count_o);
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests_run++;
      if (inst_wb_out.valid !== 1'b0) begin
        tests_failed++; $display("FAIL kill_stale c%0d: got valid rd=%0d expected no output", c, inst_wb_out.rd);
      end
    end
    check_drained("kill");
  endtask

  task automatic test_reset_mid_burst();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      inst_alu_in = mk(5'(10 + c), 32'(12288 + c));
      inst_mul_in = mk(5'(16 + c), 32'(16384 + c));
      exp_q.push_back(inst_alu_in);
      cycle();
    end
    tests_run++;
    if (dut.u_fifo.count_o !== 3'd2) begin
      tests_failed++; $display("FAIL rst_burst_pre_count: got %0d expected 2", dut.u_fifo.count_o);
    end
    idle_inputs();
    rst = 1'b1;
    cycle();
    tests_run += 4;
    if (inst_wb_out.valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_burst_valid: got %b expected 0", inst_wb_out.valid);
    end
    if (dut.u_fifo.count_o !== 3'd0) begin
      tests_failed++; $display("FAIL rst_burst_count: got %0d expected 0", dut.u_fifo.count_o);
    end
    if (stall_mul_out !== 1'b0) begin
      tests_failed++; $display("FAIL rst_burst_stall_mul: got %b expected 0", stall_mul_out);
    end
    if (stall_alu_out !== 1'b0) begin
      tests_failed++; $display("FAIL rst_burst_stall_alu: got %b expected 0", stall_alu_out);
    end
`ifdef WB_PERF_CNT_EN
    tests_run++;
    if ((conflict_cnt | mul_stall_cnt | alu_stall_cnt) !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_burst_perf: got %0d/%0d/%0d expected 0/0/0",
               conflict_cnt, mul_stall_cnt, alu_stall_cnt);
    end
`endif
    rst = 1'b0;
    repeat (2) begin
      cycle();
      tests_run++;
      if (inst_wb_out.valid !== 1'b0) begin
        tests_failed++; $display("FAIL rst_burst_stale: got valid rd=%0d expected no output", inst_wb_out.rd);
      end
    end
    check_drained("rst_burst");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mul_only();
    test_conflict();
    test_full();
    test_hazard();
    test_kill();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
